// File: rtl/id_ex_register.sv
// ID/EX pipeline register: latches decoded ID state into EX, turning bubble/flush into a NOP.
// Optional performance counters are enabled with ID_EX_PERF_COUNT_EN.
module id_ex_register #(
  parameter int unsigned CTRL_WIDTH = 16,
  parameter logic [31:0] NOP_INSTR  = 32'h00000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  bubble,
  input  logic                  valid_ID,
  input  logic [31:0]           instruction_ID,
  input  logic [31:0]           pc_ID,
  input  logic [31:0]           regAData_ID,
  input  logic [31:0]           regBData_ID,
  input  logic [31:0]           imm_ID,
  input  logic [4:0]            regA_ID,
  input  logic [4:0]            regB_ID,
  input  logic                  regARead_ID,
  input  logic                  regBRead_ID,
  input  logic [4:0]            regWrite_ID,
  input  logic                  regWriteEnable_ID,
  input  logic [CTRL_WIDTH-1:0] ctrl_ID,
  output logic                  valid_EX,
  output logic [31:0]           instruction_EX,
  output logic [31:0]           pc_EX,
  output logic [31:0]           regAData_EX,
  output logic [31:0]           regBData_EX,
  output logic [31:0]           imm_EX,
  output logic [4:0]            regA_EX,
  output logic [4:0]            regB_EX,
  output logic                  regARead_EX,
  output logic                  regBRead_EX,
  output logic [4:0]            regWrite_EX,
  output logic                  regWriteEnable_EX,
  output logic [CTRL_WIDTH-1:0] ctrl_EX,
  output logic                  holdFront
`ifdef ID_EX_PERF_COUNT_EN
  ,
  output logic [31:0]           bubbleCount,
  output logic [31:0]           flushCount
`endif
);

  // Flush wins over bubble: the dependent instruction is on the wrong path.
  assign holdFront = bubble & ~flush & ~stall;

  // Reset image and NOP image are identical, so both share one branch.
  always_ff @(posedge clk) begin
    if (rst || (!stall && (flush || bubble))) begin
      valid_EX          <= 1'b0;
      instruction_EX    <= NOP_INSTR;
      pc_EX             <= '0;
      regAData_EX       <= '0;
      regBData_EX       <= '0;
      imm_EX            <= '0;
      regA_EX           <= '0;
      regB_EX           <= '0;
      regARead_EX       <= 1'b0;
      regBRead_EX       <= 1'b0;
      regWrite_EX       <= '0;
      regWriteEnable_EX <= 1'b0;
      ctrl_EX           <= '0;
    end else if (!stall) begin
      valid_EX          <= valid_ID;
      instruction_EX    <= instruction_ID;
      pc_EX             <= pc_ID;
      regAData_EX       <= regAData_ID;
      regBData_EX       <= regBData_ID;
      imm_EX            <= imm_ID;
      regA_EX           <= regA_ID;
      regB_EX           <= regB_ID;
      regARead_EX       <= regARead_ID;
      regBRead_EX       <= regBRead_ID;
      regWrite_EX       <= regWrite_ID;
      regWriteEnable_EX <= regWriteEnable_ID;
      ctrl_EX           <= ctrl_ID;
    end
  end

`ifdef ID_EX_PERF_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bubbleCount <= '0;
      flushCount  <= '0;
    end else if (!stall) begin
      if (flush) flushCount <= flushCount + 32'd1;
      else if (bubble) bubbleCount <= bubbleCount + 32'd1;
    end
  end
`endif

endmodule

// File: doc/id_ex_register.md
Name: id_ex_register

Overview:
- ID/EX pipeline register of the 5-stage MIPS core, directly downstream of the load-use hazard unit.
- Latches decoded instruction, operands and control from ID into EX each cycle.
- Converts the hazard unit's `bubble` into an inserted NOP.
- Also handles branch flush and global halt. Outputs feed the EX stage and the hazard unit's `*_EX` inputs.

Parameters:
- CTRL_WIDTH, 16, width of the opaque control word passed ID->EX (aluOp, memRead, memWrite, etc.).
- NOP_INSTR, 32'h00000000, instruction word presented in EX for an inserted bubble or flush.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  global halt (syscall/pause); holds all state.
- flush  input  1  branch/jump taken in EX; kills the ID instruction.
- bubble  input  1  load-use hazard from the hazard unit; inserts a NOP.
- valid_ID  input  1  ID stage holds a real instruction.
- instruction_ID  input  32  instruction word in ID.
- pc_ID  input  32  PC of the ID instruction.
- regAData_ID / regBData_ID  input  32 each  register-file read data.
- imm_ID  input  32  extended immediate.
- regA_ID / regB_ID  input  5 each  source register numbers.
- regARead_ID / regBRead_ID  input  1 each  source actually used.
- regWrite_ID  input  5  destination register.
- regWriteEnable_ID  input  1  destination written.
- ctrl_ID  input  CTRL_WIDTH  control word.
- The same fields with suffix _EX  output  same widths  registered copies (instruction_EX, pc_EX, regAData_EX, regBData_EX, imm_EX, regA_EX, regB_EX, regARead_EX, regBRead_EX, regWrite_EX, regWriteEnable_EX, ctrl_EX, valid_EX).
- holdFront  output  1  combinational; asserts PC and IF/ID must hold this cycle.

Behaviour:
- Reset values: all `_EX` outputs are 0, `instruction_EX` is NOP_INSTR, `valid_EX` is 0.
- Per-edge priority, highest first:
  1. rst: load reset values.
  2. stall: hold every register unchanged.
  3. flush: load the NOP image.
  4. bubble: load the NOP image.
  5. otherwise: load all `_ID` fields, and set `valid_EX` = `valid_ID`.
- NOP image:
  - `instruction_EX` = NOP_INSTR.
  - `regWriteEnable_EX`, `regWrite_EX`, `regARead_EX`, `regBRead_EX`, `ctrl_EX`, `valid_EX` all 0.
  - `pc_EX`, data, immediate and register numbers all 0.
  - A NOP must never write a register or memory, and must never re-trigger the hazard unit.
- Latency: exactly 1 cycle ID->EX. No combinational path from any `_ID` input to any `_EX` output.
- holdFront = bubble & ~flush & ~stall.
  - While a bubble is inserted the front end holds, so the stalled load-dependent instruction re-enters ID next cycle.
  - flush overrides the bubble: the dependent instruction is on the wrong path.
  - Under stall the global halt freezes the front end independently.
- Simultaneous events:
  - flush+bubble: NOP inserted, holdFront=0.
  - stall+flush: hold. The flush takes effect on the first non-stalled edge if it is still asserted.
  - stall+bubble: hold, holdFront=0.
- Consecutive bubbles: each asserted cycle inserts one NOP. Only 1 is expected per load-use hazard, since the NOP clears `regWriteEnable_EX`.
- rst asserted mid-stream clears everything on that edge regardless of stall.

Optional Feature:
- Macro: ID_EX_PERF_COUNT_EN.
- When defined, two outputs are added:
  - bubbleCount (32): increments on each edge where a bubble NOP is loaded, i.e. priority 4 taken.
  - flushCount (32): increments on each edge where priority 3 is taken.
- Both counters clear on rst, hold under stall, and wrap modulo 2^32.
- When not defined, neither port nor logic exists; all other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with random `_ID` inputs -> `instruction_EX`=0, `valid_EX`=0, `regWriteEnable_EX`=0, all outputs 0.
- Normal flow: `instruction_ID`=32'h8C080004 (lw $8,4($0)), `pc_ID`=32'h00000010, `regWrite_ID`=8, `regWriteEnable_ID`=1, `valid_ID`=1 -> identical values on `_EX` after one edge, none before the edge.
- Load-use: lw $8 in EX, then bubble=1 for one cycle -> holdFront=1 that cycle; next edge gives `instruction_EX`=0, `regWriteEnable_EX`=0, `valid_EX`=0. Following edge loads the dependent add $9,$8,$8 (32'h01084820); bubbleCount=1 if enabled.
- Flush+bubble same cycle -> NOP loaded, holdFront=0, flushCount increments, bubbleCount unchanged.
- Stall: stall=1 for 3 cycles while `_ID` inputs change and bubble=1 -> `_EX` outputs unchanged, holdFront=0. After release, the next edge loads the current `_ID` values.
- Wrap: force bubbleCount to 32'hFFFFFFFF (ID_EX_PERF_COUNT_EN defined), insert 1 bubble -> bubbleCount=0.
